// File: rtl/buffer_pkg.sv
// Shared sizing, constants and state encoding for the buffer_64bit read-side engine.
package buffer_pkg;

  localparam int unsigned BUFF_DEPTH_DEFAULT = 256;
  localparam int unsigned BYTES_PER_WORD     = 8;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  function automatic int unsigned word_addr_w(input int unsigned depth);
    return $clog2(depth / BYTES_PER_WORD);
  endfunction

  function automatic int unsigned byte_addr_w(input int unsigned depth);
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/buffer_word_streamer_if.sv
// 8-bit valid/ready byte stream leaving the word streamer.
interface buffer_word_streamer_if;

  logic       m_valid;
  logic       m_ready;
  logic [7:0] m_data;
  logic       m_last;

  modport master (
    output m_valid,
    output m_data,
    output m_last,
    input  m_ready
  );

  modport slave (
    input  m_valid,
    input  m_data,
    input  m_last,
    output m_ready
  );

endinterface

// File: rtl/word_byte_serializer.sv
// Holds one 64-bit word and presents it LSB-first as a valid/ready byte stream.
module word_byte_serializer (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          load,
  input  logic [63:0]                   load_word,
  input  logic                          load_last,
  output logic                          can_load,
  output logic                          last_xfer,
  buffer_word_streamer_if.master        m_if
);

  logic [63:0] word_q;
  logic [2:0]  idx;
  logic        full;
  logic        last_q;
  logic        fire;

  assign fire        = full && m_if.m_ready;
  // A new word may be loaded on the same edge that retires byte 7.
  assign can_load    = !full || (fire && idx == 3'd7);
  assign m_if.m_valid = full;
  assign m_if.m_data  = word_q[{idx, 3'b000} +: 8];
  assign m_if.m_last  = full && last_q && (idx == 3'd7);
  assign last_xfer   = fire && m_if.m_last;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      word_q <= '0;
      idx    <= '0;
      full   <= 1'b0;
      last_q <= 1'b0;
    end else if (load) begin
      word_q <= load_word;
      idx    <= '0;
      full   <= 1'b1;
      last_q <= load_last;
    end else if (fire) begin
      idx <= idx + 3'd1;
      if (idx == 3'd7) begin
        full   <= 1'b0;
        last_q <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/buffer_word_streamer.sv
// Fetches a run of 64-bit words from buffer_64bit and streams them out as bytes,
// with a one-word prefetch slot so the stream stays gap-free under full ready.
module buffer_word_streamer
  import buffer_pkg::*;
#(
  parameter int unsigned BuffDepth = BUFF_DEPTH_DEFAULT,
  parameter int unsigned WordAddrW = word_addr_w(BuffDepth),
  parameter int unsigned LenW      = WordAddrW + 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [WordAddrW-1:0]  base_addr,
  input  logic [LenW-1:0]       num_words,
  output logic                  busy,
  output logic                  done,
  output logic                  buf_read_en,
  output logic                  buf_addr_mode,
  output logic [WordAddrW-1:0]  buf_word_addr,
  input  logic [63:0]           buf_word_in,
  buffer_word_streamer_if.master m_if
);

  state_t               state;
  logic [WordAddrW-1:0] base_q;
  logic [LenW-1:0]      num_q;
  logic [LenW-1:0]      req_cnt;
  logic [LenW-1:0]      ret_cnt;
  logic                 rd_pending;
  logic                 pf_valid;
  logic [63:0]          pf_word;
  logic                 pf_last;

  logic                 ser_can_load;
  logic                 last_xfer;
  logic                 ld;
  logic [63:0]          ld_word;
  logic                 ld_last;
  logic                 cap_last;
  logic                 issue;

  assign buf_addr_mode = 1'b1;

  // rd_pending marks the cycle in which buf_word_in carries the requested word.
  assign cap_last = (ret_cnt == num_q - LenW'(1));
  assign issue    = (state == RUN) && (req_cnt < num_q) && !buf_read_en && !rd_pending
                    && (!pf_valid || ser_can_load);

  always_comb begin
    ld      = 1'b0;
    ld_word = pf_word;
    ld_last = pf_last;
    if (state == RUN && ser_can_load) begin
      if (pf_valid) begin
        ld = 1'b1;
      end else if (rd_pending) begin
        ld      = 1'b1;
        ld_word = buf_word_in;
        ld_last = cap_last;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= IDLE;
      busy          <= 1'b0;
      done          <= 1'b0;
      buf_read_en   <= 1'b0;
      buf_word_addr <= '0;
      base_q        <= '0;
      num_q         <= '0;
      req_cnt       <= '0;
      ret_cnt       <= '0;
      rd_pending    <= 1'b0;
      pf_valid      <= 1'b0;
      pf_word       <= '0;
      pf_last       <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          done        <= 1'b0;
          buf_read_en <= 1'b0;
          rd_pending  <= 1'b0;
          pf_valid    <= 1'b0;
          if (start) begin
            busy    <= 1'b1;
            base_q  <= base_addr;
            num_q   <= num_words;
            ret_cnt <= '0;
            if (num_words == '0) begin
              done  <= 1'b1;
              state <= DONE;
            end else begin
              buf_read_en   <= 1'b1;
              buf_word_addr <= base_addr;
              req_cnt       <= LenW'(1);
              state         <= RUN;
            end
          end
        end
        RUN: begin
          rd_pending  <= buf_read_en;
          buf_read_en <= issue;
          if (issue) begin
            buf_word_addr <= base_q + req_cnt[WordAddrW-1:0];
            req_cnt       <= req_cnt + LenW'(1);
          end
          if (rd_pending) ret_cnt <= ret_cnt + LenW'(1);
          // Prefetch slot refills from the returning word as it drains into the serializer.
          if (pf_valid && ser_can_load) begin
            pf_valid <= rd_pending;
            pf_word  <= buf_word_in;
            pf_last  <= cap_last;
          end else if (!pf_valid && rd_pending && !ser_can_load) begin
            pf_valid <= 1'b1;
            pf_word  <= buf_word_in;
            pf_last  <= cap_last;
          end
          if (last_xfer) begin
            done  <= 1'b1;
            state <= DONE;
          end
        end
        DONE: begin
          done        <= 1'b0;
          busy        <= 1'b0;
          buf_read_en <= 1'b0;
          rd_pending  <= 1'b0;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  word_byte_serializer u_ser (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (ld),
    .load_word (ld_word),
    .load_last (ld_last),
    .can_load  (ser_can_load),
    .last_xfer (last_xfer),
    .m_if      (m_if)
  );

endmodule

// File: tb/tb_buffer_word_streamer.sv
// Randomized bench for buffer_word_streamer against a queue-based model of the byte run.
module tb_buffer_word_streamer;

  localparam int unsigned DEPTH = 256;
  localparam int unsigned NW    = DEPTH / 8;
  localparam int unsigned AW    = $clog2(NW);
  localparam int unsigned LW    = AW + 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [LW-1:0] num_words = '0;
  logic          busy, done, buf_read_en, buf_addr_mode;
  logic [AW-1:0] buf_word_addr;
  logic [63:0]   buf_word_in = '0;

  buffer_word_streamer_if sif ();

  buffer_word_streamer #(.BuffDepth(DEPTH)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .base_addr     (base_addr),
    .num_words     (num_words),
    .busy          (busy),
    .done          (done),
    .buf_read_en   (buf_read_en),
    .buf_addr_mode (buf_addr_mode),
    .buf_word_addr (buf_word_addr),
    .buf_word_in   (buf_word_in),
    .m_if          (sif)
  );

  always #5 clk = ~clk;

  // Word-mode buffer: a read sampled at an edge appears on word_out after it.
  logic [63:0] mem [NW];
  always @(posedge clk) if (buf_read_en && buf_addr_mode) buf_word_in <= mem[buf_word_addr];

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  logic [7:0]    exp_bytes [$];
  logic [AW-1:0] exp_addr  [$];
  bit            mon_en = 0;
  bit            gapless, seen_valid, stalled, prev_ren, done_seen, done_busy;
  int unsigned   reads, words_done, nbytes, start_cyc, last_hs_cyc, done_cyc, done_cnt;
  logic [7:0]    held_data;
  logic          held_last;

  always @(negedge clk) begin
    if (mon_en && rst_n) begin
      if (buf_read_en) begin
        if (exp_addr.size() == 0) check_eq("read_unexpected", buf_read_en, 0);
        else check_eq("read_addr", buf_word_addr, exp_addr.pop_front());
        check_eq("read_back_to_back", prev_ren, 0);
        reads++;
        check_eq("words_outstanding_le2", (reads - words_done) <= 2, 1);
      end
      prev_ren = buf_read_en;
      if (stalled) begin
        check_eq("stall_valid", sif.m_valid, 1);
        check_eq("stall_data", sif.m_data, held_data);
        check_eq("stall_last", sif.m_last, held_last);
        stalled = 0;
      end
      if (sif.m_valid) begin
        if (!seen_valid) begin
          seen_valid = 1;
          check_eq("first_valid_latency", cyc - start_cyc, 2);
        end
        if (sif.m_ready) begin
          if (exp_bytes.size() == 0) check_eq("byte_unexpected", sif.m_valid, 0);
          else begin
            check_eq("byte_data", sif.m_data, exp_bytes.pop_front());
            check_eq("byte_last", sif.m_last, exp_bytes.size() == 0);
          end
          nbytes++;
          if (nbytes % 8 == 0) words_done++;
          if (gapless && nbytes > 1) check_eq("stream_gap", cyc - last_hs_cyc, 1);
          last_hs_cyc = cyc;
        end else begin
          stalled   = 1;
          held_data = sif.m_data;
          held_last = sif.m_last;
        end
      end
      if (done) begin
        done_cnt++;
        if (!done_seen) begin
          done_seen = 1;
          done_cyc  = cyc;
          done_busy = busy;
        end
      end
    end
  end

  function automatic logic ready_for(input int unsigned mode, input int unsigned c);
    case (mode)
      0:       return 1'b1;
      1:       return (c % 3) == 0;
      default: return 1'($urandom_range(0, 1));
    endcase
  endfunction

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_busy"}, busy, 0);
    check_eq({tag, "_done"}, done, 0);
    check_eq({tag, "_read_en"}, buf_read_en, 0);
    check_eq({tag, "_word_addr"}, buf_word_addr, 0);
    check_eq({tag, "_m_valid"}, sif.m_valid, 0);
    check_eq({tag, "_m_data"}, sif.m_data, 0);
    check_eq({tag, "_m_last"}, sif.m_last, 0);
  endtask

  // mode: 0 ready held high, 1 one-high/two-low, 2 random. abort_at>0 resets mid-run.
  task automatic run_cmd(input int unsigned base, input int unsigned n, input int unsigned mode,
                         input bit poke_start, input int unsigned abort_at);
    int unsigned budget;
    exp_bytes.delete();
    exp_addr.delete();
    for (int unsigned w = 0; w < n; w++) begin
      logic [63:0] wd;
      wd = mem[(base + w) % NW];
      exp_addr.push_back(AW'((base + w) % NW));
      for (int unsigned k = 0; k < 8; k++) exp_bytes.push_back(wd[8*k +: 8]);
    end
    reads = 0; words_done = 0; nbytes = 0; done_cnt = 0; last_hs_cyc = 0; done_cyc = 0;
    seen_valid = 0; stalled = 0; prev_ren = 0; done_seen = 0; done_busy = 0;
    gapless = (mode == 0);
    @(posedge clk); #1;
    mon_en      = 1;
    start       = 1;
    base_addr   = AW'(base);
    num_words   = LW'(n);
    start_cyc   = cyc + 1;
    sif.m_ready = ready_for(mode, cyc);
    @(posedge clk); #1;
    start     = 0;
    base_addr = AW'($urandom);
    num_words = LW'($urandom);
    budget = 40 + 32 * n;
    for (int unsigned c = 0; c < budget && !done_seen; c++) begin
      if (abort_at != 0 && c == abort_at) break;
      sif.m_ready = ready_for(mode, cyc);
      start       = poke_start && c == 6 && busy;
      if (start) num_words = LW'(3);
      @(posedge clk); #1;
    end
    start = 0;
    if (abort_at != 0) begin
      mon_en = 0;
      rst_n  = 0;
      @(posedge clk); #1;
      check_reset_outputs("midrun_reset");
      rst_n = 1;
      repeat (6) begin
        @(posedge clk); #1;
        check_eq("post_reset_quiet", {done, busy, buf_read_en, sif.m_valid}, 0);
      end
      return;
    end
    check_eq("done_seen", done_seen, 1);
    check_eq("done_time", done_cyc, (n == 0) ? start_cyc : last_hs_cyc + 1);
    check_eq("busy_during_done", done_busy, 1);
    check_eq("busy_after_done", busy, 0);
    repeat (2) @(posedge clk);
    #1;
    mon_en = 0;
    check_eq("done_width", done_cnt, 1);
    check_eq("byte_count", nbytes, 8 * n);
    check_eq("read_count", reads, n);
  endtask

  initial begin
    for (int unsigned i = 0; i < NW; i++) mem[i] = {$urandom, $urandom};
    mem[7] = 64'h0807060504030201;
    sif.m_ready = 1'b0;
    rst_n = 0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst_n = 1;
    check_eq("addr_mode", buf_addr_mode, 1);

    run_cmd(7, 1, 0, 0, 0);
    run_cmd(0, 4, 0, 0, 0);
    run_cmd(0, 4, 1, 0, 0);
    run_cmd(31, 2, 0, 0, 0);
    run_cmd(0, 0, 0, 0, 0);
    run_cmd(3, 3, 0, 1, 0);
    run_cmd(5, 4, 0, 0, 14);
    run_cmd(9, 3, 1, 0, 0);
    repeat (12) run_cmd($urandom_range(0, NW - 1), $urandom_range(0, 6), 2, 1'($urandom_range(0, 1)), 0);
    run_cmd(20, NW, 0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/buffer_word_streamer.md
Name: buffer_word_streamer

Overview:
Read-side engine for buffer_64bit. On a start command it fetches a run of consecutive 64-bit words through the buffer's word-addressed read port. It serializes each word into an 8-bit valid/ready byte stream, least-significant byte first, which feeds downstream consumers such as the PE array input or the host readback path. A one-word prefetch slot keeps the stream gap-free while m_ready is held high.

Parameters:
BuffDepth, 256, buffer size in bytes; must match the attached buffer_64bit
WordAddrW, $clog2(BuffDepth/8), word address width
LenW, WordAddrW+1, width of the word count; legal range is 0..BuffDepth/8

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
start  in  1  command strobe; sampled only in IDLE
base_addr  in  WordAddrW  first word address
num_words  in  LenW  number of words to stream
busy  out  1  high from start acceptance until the done pulse, inclusive
done  out  1  one-cycle pulse after the last byte handshake, or after a zero-length command
buf_read_en  out  1  buffer read strobe
buf_addr_mode  out  1  tied to 1 (word mode)
buf_word_addr  out  WordAddrW  buffer word address
buf_word_in  in  64  buffer word_out
m_valid  out  1  byte valid
m_ready  in  1  downstream ready
m_data  out  8  byte payload
m_last  out  1  high with the final byte of the run

Behaviour:
- Clocking and reset: one clock, clk. Reset is synchronous and active-low (rst_n). The clock and reset port names match the rest of the codebase.
- Reset values: busy=0, done=0, buf_read_en=0, buf_word_addr=0, m_valid=0, m_data=0, m_last=0, all counters 0, prefetch slot empty, state=IDLE.
- Reset mid-run: the run is abandoned immediately. No done pulse. Any read data returning after reset is ignored.
- Buffer contract: a read strobed at edge E returns on buf_word_in after edge E and is captured by this block at edge E+1. buf_read_en is never asserted on two consecutive cycles targeting an unconsumed slot, so at most one read is in flight.
- States:
  - IDLE: waiting for start.
  - RUN: issuing reads and streaming bytes.
  - DONE: one cycle, done=1, then return to IDLE.
- IDLE transitions:
  - start with num_words=0: go to DONE next cycle. No buffer access.
  - start with num_words>0: latch base_addr and num_words, set busy, go to RUN.
- Read issue (RUN):
  - buf_read_en is registered.
  - Assert it for one cycle when all hold: the request count is below num_words, no read is in flight, and the prefetch slot is empty or will be drained this cycle.
  - buf_word_addr = (base_addr + request count) mod (BuffDepth/8). Addresses wrap silently from the top word to word 0.
- Data path:
  - The returning word goes to the output shift register if it is empty, otherwise to the prefetch slot.
  - The output register presents byte k = word[8k+7:8k] for k = 0..7.
  - On each m_valid && m_ready, k advances. At k=7 the prefetch word, if present, loads in the same cycle, so there is no bubble.
- Latency: start accepted at edge E0 → buf_read_en high in the cycle after E0 → first m_valid high after edge E0+2 (E2).
  - With m_ready held high, 8×N bytes are delivered on consecutive cycles.
- Handshake rules:
  - m_data and m_last hold stable while m_valid && !m_ready.
  - m_valid never drops without a handshake.
  - m_last=1 only on byte 7 of word N-1.
- End of run: the handshake of the last byte moves RUN to DONE. busy stays high through the DONE cycle and falls the cycle after.
- start outside IDLE is ignored.

Decomposition:
- Package buffer_pkg:
  - BuffDepth default, WordAddrW and ByteAddrW calculations.
  - BYTES_PER_WORD = 8.
  - State enum {IDLE, RUN, DONE}.
- One natural sub-module, word_byte_serializer: a 64-bit load, 8-bit valid/ready output with a byte index counter, an empty flag and a last-word tag input. The top level holds the FSM, the address/request counters and the prefetch slot.

Test Plan:
- Single word: buffer word 7 = 64'h0807060504030201, start with base=7, n=1, m_ready=1 → exactly one read at addr 7; m_data 01..08 on 8 consecutive cycles; m_last on 08; done one cycle later.
- Streaming: words 0..3 hold distinct patterns, base=0, n=4, m_ready=1 → 32 bytes with no m_valid gaps; 4 reads at addrs 0,1,2,3; at most one read in flight.
- Backpressure: same as the streaming case with m_ready toggling on a 1-high/2-low pattern → m_data stable while stalled; byte order and count unchanged; never more than one read in flight or more than one buffered word beyond the output register.
- Wrap and zero length: base=31 (BuffDepth=256), n=2 → reads at addrs 31 then 0. Separately, n=0 → done pulse one cycle after start, buf_read_en never high.
- Control corners: start pulsed while busy → ignored, byte count unchanged. rst_n=0 mid-stream → next cycle all outputs at reset values, no done pulse; a fresh start afterwards streams correctly.
